// File: rtl/dsp_seq_pkg.sv
// Shared types and widths for the DSP operation sequencer.
package dsp_seq_pkg;

  localparam int OPERAND_W = 4;
  localparam int RESULT_W  = 8;
  localparam int CNT_W     = 8;

  // Encodings are visible on the debug LEDs, so they are pinned explicitly.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_B = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    SHOW   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/seq_timer.sv
// Saturating WAIT-state cycle counter; expired flags the final allowed cycle.
module seq_timer
  import dsp_seq_pkg::*;
#(
  parameter int LIMIT = 200
) (
  input  logic             clock_in,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT  = '1;

  always_ff @(posedge clock_in) begin
    if (clear) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + 1'b1;
    end
  end

  // Count reads k-1 during the k-th WAIT cycle.
  assign expired = (count >= LAST);

endmodule

// File: rtl/dsp_op_sequencer.sv
// Two-operand push sequencer driving a DSP datapath and a result display.
// Define DSP_SEQ_TIMEOUT_EN to enable the WAIT timeout and the ERR path.
module dsp_op_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic                 clock_in,
  input  logic                 clr,
  input  logic                 push_pulse,
  input  logic [OPERAND_W-1:0] op_in,
  input  logic                 dsp_done,
  input  logic [RESULT_W-1:0]  dsp_result,
  output logic [OPERAND_W-1:0] operand_a,
  output logic [OPERAND_W-1:0] operand_b,
  output logic                 dsp_start,
  output logic [RESULT_W-1:0]  disp_value,
  output logic                 disp_valid,
  output logic                 busy,
  output logic                 error,
  output logic [2:0]           state_o
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_t state, state_next;
  logic   load_a, load_b, latch_result;

`ifdef DSP_SEQ_TIMEOUT_EN
  logic             timeout;
  logic [CNT_W-1:0] wait_cnt_unused;

  // Clearing during START guarantees the count starts at zero on WAIT entry.
  seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clock_in (clock_in),
    .clear    (clr || (state == START)),
    .enable   (state == WAIT),
    .count    (wait_cnt_unused),
    .expired  (timeout)
  );
`else
  assign error = 1'b0;
`endif

  always_comb begin
    state_next   = state;
    load_a       = 1'b0;
    load_b       = 1'b0;
    latch_result = 1'b0;
    case (state)
      IDLE, SHOW: begin
        if (push_pulse) begin
          load_a     = 1'b1;
          state_next = LOAD_B;
        end
      end
      LOAD_B: begin
        if (push_pulse) begin
          load_b     = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        // A completion in the final allowed cycle wins over the timeout.
        if (dsp_done) begin
          latch_result = 1'b1;
          state_next   = SHOW;
        end
`ifdef DSP_SEQ_TIMEOUT_EN
        else if (timeout) begin
          state_next = ERR;
        end
`endif
      end
      ERR: begin
        if (push_pulse) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with state_o.
  always_ff @(posedge clock_in) begin
    if (clr) begin
      state      <= IDLE;
      operand_a  <= '0;
      operand_b  <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
      dsp_start  <= 1'b0;
      busy       <= 1'b0;
`ifdef DSP_SEQ_TIMEOUT_EN
      error      <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      if (load_a)       operand_a  <= op_in;
      if (load_b)       operand_b  <= op_in;
      if (latch_result) disp_value <= dsp_result;
      disp_valid <= (state_next == SHOW);
      dsp_start  <= (state_next == START);
      busy       <= (state_next == START) || (state_next == WAIT);
`ifdef DSP_SEQ_TIMEOUT_EN
      error      <= (state_next == ERR);
`endif
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Self-checking bench for dsp_op_sequencer, built with TIMEOUT_CYCLES=10.
module tb_dsp_op_sequencer;

  logic       clock_in = 1'b0;
  logic       clr = 1'b0;
  logic       push_pulse = 1'b0;
  logic [3:0] op_in = '0;
  logic       dsp_done = 1'b0;
  logic [7:0] dsp_result = '0;
  logic [3:0] operand_a, operand_b;
  logic       dsp_start;
  logic [7:0] disp_value;
  logic       disp_valid, busy, error;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_val;

  dsp_op_sequencer #(.TIMEOUT_CYCLES(10)) dut (
    .clock_in   (clock_in),
    .clr        (clr),
    .push_pulse (push_pulse),
    .op_in      (op_in),
    .dsp_done   (dsp_done),
    .dsp_result (dsp_result),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .dsp_start  (dsp_start),
    .disp_value (disp_value),
    .disp_valid (disp_valid),
    .busy       (busy),
    .error      (error),
    .state_o    (state_o)
  );

  always #5 clock_in = ~clock_in;

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_push(input logic [3:0] v);
    op_in      = v;
    push_pulse = 1'b1;
    cyc();
    push_pulse = 1'b0;
  endtask

  // Completion strobe; the expected display value goes to the scoreboard.
  task automatic do_done(input logic [7:0] r);
    dsp_result = r;
    dsp_done   = 1'b1;
    exp_q.push_back(r);
    cyc();
    dsp_done   = 1'b0;
    dsp_result = 8'hXX;
  endtask

  task automatic pop_expected(output logic [7:0] v);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got size 0 expected >0");
      v = 8'hXX;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
    checks++; if (operand_a !== 4'd0 || operand_b !== 4'd0) begin errors++; $display("[TB] FAIL reset_operands: got %0h/%0h expected 0/0", operand_a, operand_b); end
    checks++; if (disp_value !== 8'd0 || disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_disp: got %0h/%0b expected 0/0", disp_value, disp_valid); end
    checks++; if (dsp_start !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got start=%0b busy=%0b err=%0b expected 0", dsp_start, busy, error); end
`ifdef DSP_SEQ_TIMEOUT_EN
    checks++; if (dut.u_timer.count !== 8'd0) begin errors++; $display("[TB] FAIL reset_counter: got %0d expected 0", dut.u_timer.count); end
`endif
  endtask

  task automatic test_normal();
    do_push(4'd3);
    checks++; if (state_o !== 3'd1 || operand_a !== 4'd3) begin errors++; $display("[TB] FAIL load_a: got state=%0d a=%0h expected 1/3", state_o, operand_a); end
    do_push(4'd5);
    checks++; if (state_o !== 3'd2 || operand_b !== 4'd5) begin errors++; $display("[TB] FAIL load_b: got state=%0d b=%0h expected 2/5", state_o, operand_b); end
    checks++; if (dsp_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_strobe: got start=%0b busy=%0b expected 1/1", dsp_start, busy); end
    cyc();
    checks++; if (state_o !== 3'd3 || dsp_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL wait_entry: got state=%0d start=%0b busy=%0b expected 3/0/1", state_o, dsp_start, busy); end
    repeat (3) cyc();
    do_done(8'h0F);
    pop_expected(exp_val);
    checks++; if (state_o !== 3'd4 || disp_value !== exp_val || disp_valid !== 1'b1) begin errors++; $display("[TB] FAIL show_result: got state=%0d val=%0h valid=%0b expected 4/%0h/1", state_o, disp_value, disp_valid, exp_val); end
    checks++; if (busy !== 1'b0 || operand_a !== 4'd3 || operand_b !== 4'd5) begin errors++; $display("[TB] FAIL show_hold: got busy=%0b a=%0h b=%0h expected 0/3/5", busy, operand_a, operand_b); end
  endtask

  task automatic test_back_to_back();
    do_push(4'd7);
    checks++; if (state_o !== 3'd1 || operand_a !== 4'd7) begin errors++; $display("[TB] FAIL b2b_load: got state=%0d a=%0h expected 1/7", state_o, operand_a); end
    checks++; if (disp_valid !== 1'b0 || disp_value !== 8'h0F) begin errors++; $display("[TB] FAIL b2b_disp: got valid=%0b val=%0h expected 0/0f", disp_valid, disp_value); end
  endtask

  task automatic test_ignored();
    do_push(4'd9);
    cyc();
    op_in      = 4'hE;
    push_pulse = 1'b1;
    cyc();
    push_pulse = 1'b0;
    checks++; if (state_o !== 3'd3 || operand_a !== 4'd7 || operand_b !== 4'd9) begin errors++; $display("[TB] FAIL push_in_wait: got state=%0d a=%0h b=%0h expected 3/7/9", state_o, operand_a, operand_b); end
    checks++; if (disp_value !== 8'h0F) begin errors++; $display("[TB] FAIL disp_hold_wait: got %0h expected 0f", disp_value); end
    do_done(8'h55);
    pop_expected(exp_val);
    checks++; if (state_o !== 3'd4 || disp_value !== exp_val) begin errors++; $display("[TB] FAIL second_result: got state=%0d val=%0h expected 4/%0h", state_o, disp_value, exp_val); end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    dsp_result = 8'hAA;
    dsp_done   = 1'b1;
    cyc();
    dsp_done   = 1'b0;
    checks++; if (state_o !== 3'd0 || disp_value !== 8'h00 || disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL done_in_idle: got state=%0d val=%0h valid=%0b expected 0/0/0", state_o, disp_value, disp_valid); end
    checks++; if (operand_a !== 4'd0 || operand_b !== 4'd0) begin errors++; $display("[TB] FAIL idle_operands: got %0h/%0h expected 0/0", operand_a, operand_b); end
  endtask

  task automatic test_timeout();
    do_push(4'd1);
    do_push(4'd2);
    cyc();
    repeat (9) cyc();
    checks++; if (state_o !== 3'd3 || error !== 1'b0) begin errors++; $display("[TB] FAIL wait_cycle10: got state=%0d err=%0b expected 3/0", state_o, error); end
    cyc();
`ifdef DSP_SEQ_TIMEOUT_EN
    checks++; if (state_o !== 3'd5 || error !== 1'b1 || disp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_err: got state=%0d err=%0b valid=%0b busy=%0b expected 5/1/0/0", state_o, error, disp_valid, busy); end
    do_push(4'hF);
    checks++; if (state_o !== 3'd0 || error !== 1'b0) begin errors++; $display("[TB] FAIL err_exit: got state=%0d err=%0b expected 0/0", state_o, error); end
    checks++; if (operand_a !== 4'd1 || operand_b !== 4'd2) begin errors++; $display("[TB] FAIL err_operands: got %0h/%0h expected 1/2", operand_a, operand_b); end
`else
    checks++; if (state_o !== 3'd3 || error !== 1'b0) begin errors++; $display("[TB] FAIL no_timeout: got state=%0d err=%0b expected 3/0", state_o, error); end
    do_done(8'h11);
    pop_expected(exp_val);
    checks++; if (state_o !== 3'd4 || disp_value !== exp_val) begin errors++; $display("[TB] FAIL late_done: got state=%0d val=%0h expected 4/%0h", state_o, disp_value, exp_val); end
`endif
  endtask

  task automatic test_collision();
    do_push(4'd6);
    do_push(4'd4);
    cyc();
    repeat (9) cyc();
    do_done(8'h2A);
    pop_expected(exp_val);
    checks++; if (state_o !== 3'd4 || disp_value !== exp_val || error !== 1'b0 || disp_valid !== 1'b1) begin errors++; $display("[TB] FAIL collision: got state=%0d val=%0h err=%0b valid=%0b expected 4/%0h/0/1", state_o, disp_value, error, disp_valid, exp_val); end
  endtask

  task automatic test_mid_reset();
    do_push(4'd2);
    do_push(4'd8);
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    checks++; if (state_o !== 3'd0 || operand_a !== 4'd0 || operand_b !== 4'd0 || disp_value !== 8'd0) begin errors++; $display("[TB] FAIL midreset_values: got state=%0d a=%0h b=%0h val=%0h expected 0", state_o, operand_a, operand_b, disp_value); end
    checks++; if (disp_valid !== 1'b0 || dsp_start !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags: got valid=%0b start=%0b busy=%0b err=%0b expected 0", disp_valid, dsp_start, busy, error); end
    dsp_result = 8'h77;
    dsp_done   = 1'b1;
    cyc();
    dsp_done   = 1'b0;
    checks++; if (state_o !== 3'd0 || disp_value !== 8'd0 || disp_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got state=%0d val=%0h valid=%0b expected 0/0/0", state_o, disp_value, disp_valid); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cyc();
    test_reset();
    test_normal();
    test_back_to_back();
    test_ignored();
    test_timeout();
    test_collision();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
